// File: rtl/mips_prog_loader.sv
// mips_prog_loader: framed byte-stream loader writing big-endian words to MIPS memory; `define MIPS_LOADER_OPCHK_EN adds opcode screening
module mips_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              error,
  output logic              cpu_run,
  output logic [15:0]       word_cnt
);
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  state_t state, state_n;
  logic [7:0]  len_hi, xsum;
  logic [15:0] len;
  logic [23:0] asm_r;
  logic [1:0]  idx;
  logic [31:0] word_n;
  logic        xfer, word_done, last_word, op_bad, rearm_go;
  assign xfer      = in_valid & in_ready;
  assign word_n    = {asm_r, in_data};
  assign word_done = xfer && state == S_DATA && idx == 2'd3;
  assign last_word = word_cnt + 16'd1 == len;
  assign rearm_go  = rearm && (state == S_DONE || state == S_ERR);
  assign cpu_run   = done;
`ifdef MIPS_LOADER_OPCHK_EN
  logic [5:0] op;
  assign op     = word_n[31:26];
  assign op_bad = !(op <= 6'd5 || (op >= 6'd8 && op <= 6'd14) || op == 6'h3F);
`else
  assign op_bad = 1'b0;
`endif
  // next-state: length parse, word counting, checksum verdict, rearm from terminal states
  always_comb begin
    state_n = state;
    case (state)
      S_LEN0: state_n = xfer ? S_LEN1 : S_LEN0;
      S_LEN1: if (xfer) state_n = 32'({len_hi, in_data}) > MAX_WORDS ? S_ERR :
                                  {len_hi, in_data} == 16'd0 ? S_CSUM : S_DATA;
      S_DATA: if (word_done) state_n = op_bad ? S_ERR : last_word ? S_CSUM : S_DATA;
      S_CSUM: if (xfer) state_n = in_data == xsum ? S_DONE : S_ERR;
      default: state_n = rearm_go ? S_LEN0 : state;
    endcase
  end
  // state, registered outputs, word assembly and running XOR
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LEN0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      mem_wdata <= '0;
      word_cnt  <= '0;
      xsum      <= '0;
      idx       <= '0;
      len_hi    <= '0;
      len       <= '0;
      asm_r     <= '0;
    end else begin
      state    <= state_n;
      in_ready <= state_n != S_DONE && state_n != S_ERR;
      mem_we   <= word_done && !op_bad;
      done     <= state_n == S_DONE;
      error    <= state_n == S_ERR;
      if (rearm_go) begin
        word_cnt <= '0;
        xsum     <= '0;
        idx      <= '0;
        mem_addr <= ADDR_W'(BASE_ADDR);
      end else if (xfer) begin
        if (state != S_CSUM) xsum <= xsum ^ in_data;
        if (state == S_LEN0) len_hi <= in_data;
        if (state == S_LEN1) len <= {len_hi, in_data};
        if (state == S_DATA) begin
          asm_r <= word_n[23:0];
          idx   <= idx + 2'd1;
        end
        if (word_done && !op_bad) begin
          mem_addr  <= ADDR_W'(BASE_ADDR) + word_cnt[ADDR_W-1:0];
          mem_wdata <= word_n;
          word_cnt  <= word_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
Byte-stream program loader; the writer side of the MIPS instruction/data memory that the pipeline's fetch and MEM stages read. It receives a framed image over a valid/ready byte interface, assembles 32-bit big-endian words and writes them sequentially into `mem`. After a checksum-verified image it releases the core via `cpu_run`; until then the core stays halted.

Parameters:
ADDR_W, 10, memory word-address width (1024-word `mem`)
BASE_ADDR, 0, word address of the first loaded instruction
MAX_WORDS, 1024, largest legal word count in a frame

Ports:
clk  in  1  single system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  byte available
in_data  in  8  stream byte
in_ready  out  1  loader accepts byte; transfer = in_valid & in_ready at posedge clk
rearm  in  1  one-cycle pulse; restart loader from DONE/ERR
mem_we  out  1  one-cycle memory write strobe
mem_addr  out  ADDR_W  word address for write
mem_wdata  out  32  word to write
done  out  1  image loaded and verified (sticky)
error  out  1  framing/checksum/length fault (sticky)
cpu_run  out  1  release to processor; equals done
word_cnt  out  16  words written so far in current frame

Behaviour:
- Frame: LEN_HI, LEN_LO (16-bit count N, big-endian), then N×4 data bytes (MSB first), then 1 checksum byte. Checksum = 8-bit XOR of all preceding frame bytes including both length bytes.
- Reset (sync, rst=1 at posedge): state=S_LEN0; in_ready, mem_we, done, error, cpu_run = 0; mem_addr=BASE_ADDR; mem_wdata=0; word_cnt=0; internal XOR=0; byte index=0. Already-written memory is untouched.
- in_ready is registered: 1 in S_LEN0, S_LEN1, S_DATA and S_CSUM; 0 in S_DONE and S_ERR. The first cycle after reset is 0.
- S_LEN0: on transfer, latch high byte → S_LEN1.
- S_LEN1: on transfer, latch low byte. If N > MAX_WORDS → S_ERR. If N == 0 → S_CSUM. Otherwise → S_DATA.
- S_DATA: shift bytes into a 32-bit assembly register, with a 2-bit byte index 0..3. On the 4th byte transfer at edge k, at edge k+1:
  - mem_we=1 for exactly one cycle;
  - mem_addr = BASE_ADDR + word_cnt (wraps mod 2^ADDR_W);
  - mem_wdata = assembled word;
  - word_cnt increments.
  After the N-th word → S_CSUM.
- Write latency: 1 cycle after the last byte of a word. No backpressure from memory; in_ready stays 1 in S_DATA, so back-to-back bytes run at full rate.
- Idle cycles (in_valid=0) in any state: no state change.
- S_CSUM: on transfer, compare the byte to the running XOR. Match → S_DONE (done=cpu_run=1 next edge). Mismatch → S_ERR (error=1 next edge).
- S_DONE / S_ERR: hold. A rearm pulse returns to S_LEN0 and clears done, error, cpu_run, word_cnt and XOR; mem_addr returns to BASE_ADDR. rearm in any other state is ignored.
- rst and rearm in the same cycle: rst wins.
- done and error are never 1 simultaneously.

Optional Feature:
- Macro: MIPS_LOADER_OPCHK_EN.
- Defined: each assembled word's opcode [31:26] is checked against the legal set 000000–000101, 001000–001110 and 111111. An illegal opcode suppresses that word's mem_we and goes → S_ERR at the same edge the write would have occurred.
- Undefined: no opcode check; every word is written.

Test Plan:
- Stream 00 02 00 22 18 00 FC 00 00 00 C4 with in_valid held high → mem_we at addr 0 with data 0x00221800, then addr 1 with 0xFC000000; word_cnt=2; done=cpu_run=1; error=0; in_ready drops to 0.
- Same stream with checksum C5 → both writes occur; error=1; done=cpu_run=0. A rearm pulse then returns in_ready=1, error=0, word_cnt=0.
- Length bytes 04 01 (N=1025, MAX_WORDS=1024) → error=1 one edge after the 2nd byte; no mem_we; in_ready=0.
- Stream 00 00 00 (N=0) → done=1 and no mem_we. Separately, the first stream with 3 idle cycles inserted between every byte → identical writes and done=1.
- Assert rst during S_DATA after 2 of 4 bytes, then send the full first stream → exactly the 2 expected writes starting at addr 0, and done=1.
- With MIPS_LOADER_OPCHK_EN, stream 00 01 40 00 00 00 41 (opcode 010000) → no mem_we; error=1 after the 4th data byte. Without the macro, the same stream → write 0x40000000 at addr 0, then done=1.
